// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word and the cache-arbiter FSM states.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the I-cache and D-cache.
// Commands are latched at grant and replayed until memory responds.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  rv32i_word         i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  rv32i_word         d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output rv32i_word         pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t        state_q, state_d;
    logic              last_d_q, last_d_d;
    rv32i_word         addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, D wins unless D was the last one served.
                if (d_req && (!i_req || !last_d_q)) begin
                    state_d = SERVE_D;
                    addr_d  = d_pmem_address;
                    wdata_d = d_pmem_wdata;
                    wr_d    = d_pmem_write;
                    rd_d    = ~d_pmem_write;
                end else if (i_req) begin
                    state_d = SERVE_I;
                    addr_d  = i_pmem_address;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
                end
            end
            SERVE_I: begin
                pmem_read  = rd_q;
                pmem_write = wr_q;
                if (pmem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_d     = IDLE;
                    last_d_d    = 1'b0;
                end
            end
            SERVE_D: begin
                pmem_read  = rd_q;
                pmem_write = wr_q;
                if (pmem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_d     = IDLE;
                    last_d_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
